// File: rtl/oc_guard_if.sv
// Signal bundle between the overcurrent guard and its surroundings:
// comparator/operator inputs in, PWM-kill and status outputs back.
interface oc_guard_if;
    logic       sense_in;
    logic       clear;
    logic       oc;
    logic       lockout;
    logic [3:0] retry_count;
    logic [7:0] trip_count;

    modport master (
        output sense_in,
        output clear,
        input  oc,
        input  lockout,
        input  retry_count,
        input  trip_count
    );

    modport slave (
        input  sense_in,
        input  clear,
        output oc,
        output lockout,
        output retry_count,
        output trip_count
    );
endinterface

// File: rtl/oc_guard.sv
// Overcurrent qualification and trip manager: synchronizes the comparator,
// qualifies sustained faults, enforces cooldown and latches lockout after repeated trips.
module oc_guard #(
    parameter int unsigned QUAL_CYCLES     = 1000,
    parameter int unsigned COOLDOWN_CYCLES = 50000000,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic       clock,
    input  logic       reset,
    oc_guard_if.slave  bus
);
    localparam int QW = $clog2(QUAL_CYCLES + 1);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    localparam logic [QW-1:0] QUAL_MAX  = QW'(QUAL_CYCLES);
    localparam logic [QW-1:0] QUAL_ONE  = QW'(1);
    localparam logic [CW-1:0] COOL_MAX  = CW'(COOLDOWN_CYCLES);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [CW-1:0] COOL_ONE  = CW'(1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        TRIP    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sync_q, sync_d;
    logic          sense_s_q, sense_s_d;
    logic [QW-1:0] qual_cnt_q, qual_cnt_d;
    logic [CW-1:0] cool_cnt_q, cool_cnt_d;
    logic [CW-1:0] decay_cnt_q, decay_cnt_d;
    logic          oc_q, oc_d;
    logic          lockout_q, lockout_d;
    logic [3:0]    retry_count_q, retry_count_d;
    logic [7:0]    trip_count_q, trip_count_d;
    logic [3:0]    retry_inc;
    logic [7:0]    trip_inc;

    always_comb begin
        state_d       = state_q;
        sync_d        = bus.sense_in;
        sense_s_d     = sync_q;
        qual_cnt_d    = qual_cnt_q;
        cool_cnt_d    = cool_cnt_q;
        decay_cnt_d   = decay_cnt_q;
        oc_d          = oc_q;
        lockout_d     = lockout_q;
        retry_count_d = retry_count_q;
        trip_count_d  = trip_count_q;
        retry_inc     = (retry_count_q == 4'hF) ? retry_count_q : retry_count_q + 4'd1;
        trip_inc      = (trip_count_q == 8'hFF) ? trip_count_q : trip_count_q + 8'd1;

        case (state_q)
            ARMED: begin
                // A qualified trip takes priority over the decay terminal count.
                if (qual_cnt_q == QUAL_MAX) begin
                    retry_count_d = retry_inc;
                    trip_count_d  = trip_inc;
                    qual_cnt_d    = '0;
                    cool_cnt_d    = '0;
                    decay_cnt_d   = '0;
                    oc_d          = 1'b1;
                    if (retry_inc >= RETRY_MAX) begin
                        state_d   = LOCKOUT;
                        lockout_d = 1'b1;
                    end else begin
                        state_d   = TRIP;
                    end
                end else begin
                    qual_cnt_d = sense_s_q ? qual_cnt_q + QUAL_ONE : '0;
                    if (decay_cnt_q != COOL_MAX) begin
                        decay_cnt_d = decay_cnt_q + COOL_ONE;
                        if (decay_cnt_q == COOL_LAST) begin
                            retry_count_d = '0;
                        end
                    end
                end
            end
            TRIP: begin
                if (cool_cnt_q == COOL_LAST) begin
                    state_d     = ARMED;
                    oc_d        = 1'b0;
                    qual_cnt_d  = '0;
                    decay_cnt_d = '0;
                end else begin
                    cool_cnt_d  = cool_cnt_q + COOL_ONE;
                end
            end
            LOCKOUT: begin
                if (bus.clear && !sense_s_q) begin
                    state_d       = ARMED;
                    oc_d          = 1'b0;
                    lockout_d     = 1'b0;
                    retry_count_d = '0;
                    qual_cnt_d    = '0;
                    decay_cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ARMED;
            sync_q        <= 1'b0;
            sense_s_q     <= 1'b0;
            qual_cnt_q    <= '0;
            cool_cnt_q    <= '0;
            decay_cnt_q   <= '0;
            oc_q          <= 1'b0;
            lockout_q     <= 1'b0;
            retry_count_q <= '0;
            trip_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            sense_s_q     <= sense_s_d;
            qual_cnt_q    <= qual_cnt_d;
            cool_cnt_q    <= cool_cnt_d;
            decay_cnt_q   <= decay_cnt_d;
            oc_q          <= oc_d;
            lockout_q     <= lockout_d;
            retry_count_q <= retry_count_d;
            trip_count_q  <= trip_count_d;
        end
    end

    assign bus.oc          = oc_q;
    assign bus.lockout     = lockout_q;
    assign bus.retry_count = retry_count_q;
    assign bus.trip_count  = trip_count_q;
endmodule
